// File: rtl/df_rd_ctrl.sv
// Read-domain controller of the dual-clock FIFO: pointer/level/flag logic, read
// sequencing into the 1-cycle-latency memory, and a 2-entry prefetch buffer.
module df_rd_ctrl #(
   parameter  int ADDR_WIDTH = 3,
   parameter  int DATA_WIDTH = 8,
   parameter  int AEMPTY_TH  = 2,
   localparam int PW         = ADDR_WIDTH + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [PW-1:0]         sync_wr_gray,
   output logic [PW-1:0]         rd_gray,
   output logic [ADDR_WIDTH-1:0] mem_raddr,
   output logic                  mem_ren,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  empty,
   output logic                  aempty,
   output logic [PW-1:0]         rd_level,
   output logic                  ptr_err
);

   localparam logic [PW-1:0] DEPTH = PW'(1 << ADDR_WIDTH);
   localparam logic [PW-1:0] AE_TH = PW'(AEMPTY_TH);

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   logic [PW-1:0]         rd_bin;
   logic [PW-1:0]         rd_bin_nxt;
   logic [PW-1:0]         wr_bin;
   logic [PW-1:0]         level;
   logic                  inflight;
   logic [1:0]            buf_cnt;
   logic [1:0]            occ;
   logic [DATA_WIDTH-1:0] tail;
   logic                  fifo_empty;
   logic                  pop;

   assign wr_bin     = gray2bin(sync_wr_gray);
   assign level      = wr_bin - rd_bin;
   assign rd_level   = level;
   assign fifo_empty = (sync_wr_gray == rd_gray);
   assign aempty     = (level <= AE_TH);
   assign pop        = m_valid & m_ready;
   assign occ        = buf_cnt + {1'b0, inflight};
   assign rd_bin_nxt = rd_bin + 1'b1;
   assign mem_raddr  = rd_bin[ADDR_WIDTH-1:0];
   assign empty      = fifo_empty & !inflight & (buf_cnt == 2'd0);

   // Gated by rst_n so the enable is quiet while reset is held, even if the
   // synchronized write pointer has not yet returned to zero.
   assign mem_ren = rst_n & !fifo_empty & ((occ < 2'd2) | ((occ == 2'd2) & pop));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_bin   <= '0;
         rd_gray  <= '0;
         inflight <= 1'b0;
         buf_cnt  <= 2'd0;
         tail     <= '0;
         m_data   <= '0;
         m_valid  <= 1'b0;
         ptr_err  <= 1'b0;
      end else begin
         if (mem_ren) begin
            rd_bin  <= rd_bin_nxt;
            rd_gray <= rd_bin_nxt ^ (rd_bin_nxt >> 1);
         end
         inflight <= mem_ren;
         if (level > DEPTH) ptr_err <= 1'b1;

         // inflight marks the cycle mem_rdata is valid: that is the buffer push
         unique case ({inflight, pop})
            2'b10: begin
               if (buf_cnt == 2'd0) m_data <= mem_rdata;
               else                 tail   <= mem_rdata;
               buf_cnt <= buf_cnt + 2'd1;
               m_valid <= 1'b1;
            end
            2'b01: begin
               if (buf_cnt == 2'd2) m_data <= tail;
               buf_cnt <= buf_cnt - 2'd1;
               m_valid <= (buf_cnt == 2'd2);
            end
            2'b11: begin
               if (buf_cnt == 2'd1) begin
                  m_data <= mem_rdata;
               end else begin
                  m_data <= tail;
                  tail   <= mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_df_rd_ctrl.sv
// Directed bench for df_rd_ctrl with a behavioural 1-cycle-latency memory.
module tb_df_rd_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] sync_wr_gray;
   logic [3:0] rd_gray;
   logic [2:0] mem_raddr;
   logic       mem_ren;
   logic [7:0] mem_rdata;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic       empty;
   logic       aempty;
   logic [3:0] rd_level;
   logic       ptr_err;

   logic [7:0] mem [8];
   int checks = 0;
   int errors = 0;

   df_rd_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .AEMPTY_TH(2)) dut (
      .clk(clk), .rst_n(rst_n), .sync_wr_gray(sync_wr_gray), .rd_gray(rd_gray),
      .mem_raddr(mem_raddr), .mem_ren(mem_ren), .mem_rdata(mem_rdata),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .empty(empty),
      .aempty(aempty), .rd_level(rd_level), .ptr_err(ptr_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_raddr];

   function automatic logic [3:0] gray(input logic [3:0] n);
      return n ^ (n >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #2;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      sync_wr_gray = 4'd0;
      m_ready = 1'b0;
      step;
      step;
      rst_n = 1'b1;
      settle;
   endtask

   initial begin
      int n;
      for (int i = 0; i < 8; i++) mem[i] = 8'(8'h30 + i * 7);
      mem_rdata = 8'h00;

      // reset state
      do_reset;
      chk("rst_empty",    32'(empty),    32'd1);
      chk("rst_aempty",   32'(aempty),   32'd1);
      chk("rst_level",    32'(rd_level), 32'd0);
      chk("rst_valid",    32'(m_valid),  32'd0);
      chk("rst_ren",      32'(mem_ren),  32'd0);
      chk("rst_gray",     32'(rd_gray),  32'd0);
      chk("rst_ptr_err",  32'(ptr_err),  32'd0);

      // single word, consumer stalled
      sync_wr_gray = 4'b0001;
      settle;
      chk("w1_ren_t",    32'(mem_ren),   32'd1);
      chk("w1_raddr",    32'(mem_raddr), 32'd0);
      chk("w1_level",    32'(rd_level),  32'd1);
      chk("w1_empty_t",  32'(empty),     32'd0);
      step;
      chk("w1_ren_t1",   32'(mem_ren),   32'd0);
      chk("w1_gray",     32'(rd_gray),   32'd1);
      chk("w1_valid_t1", 32'(m_valid),   32'd0);
      chk("w1_empty_t1", 32'(empty),     32'd0);
      step;
      chk("w1_valid_t2", 32'(m_valid),   32'd1);
      chk("w1_data_t2",  32'(m_data),    32'(mem[0]));
      step;
      chk("w1_hold_v",   32'(m_valid),   32'd1);
      chk("w1_hold_d",   32'(m_data),    32'(mem[0]));
      m_ready = 1'b1;
      step;
      chk("w1_pop_v",    32'(m_valid),   32'd0);
      chk("w1_pop_empty",32'(empty),     32'd1);
      m_ready = 1'b0;

      // five words, buffer fills to 2 and issue stops
      do_reset;
      sync_wr_gray = 4'b0111;
      settle;
      chk("w5_ren0",   32'(mem_ren),   32'd1);
      chk("w5_addr0",  32'(mem_raddr), 32'd0);
      chk("w5_lvl5",   32'(rd_level),  32'd5);
      chk("w5_ae5",    32'(aempty),    32'd0);
      step;
      chk("w5_ren1",   32'(mem_ren),   32'd1);
      chk("w5_addr1",  32'(mem_raddr), 32'd1);
      chk("w5_lvl4",   32'(rd_level),  32'd4);
      step;
      chk("w5_ren2",   32'(mem_ren),   32'd0);
      chk("w5_lvl3",   32'(rd_level),  32'd3);
      chk("w5_ae3",    32'(aempty),    32'd0);
      chk("w5_valid",  32'(m_valid),   32'd1);
      chk("w5_data0",  32'(m_data),    32'(mem[0]));
      step;
      chk("w5_ren3",   32'(mem_ren),   32'd0);
      chk("w5_data0b", 32'(m_data),    32'(mem[0]));
      m_ready = 1'b1;
      settle;
      chk("w5_ren_pop",  32'(mem_ren),   32'd1);
      chk("w5_addr2",    32'(mem_raddr), 32'd2);
      step;
      m_ready = 1'b0;
      settle;
      chk("w5_lvl2",   32'(rd_level),  32'd2);
      chk("w5_ae2",    32'(aempty),    32'd1);
      chk("w5_data1",  32'(m_data),    32'(mem[1]));
      chk("w5_valid1", 32'(m_valid),   32'd1);

      // full FIFO streamed out at one word per cycle
      do_reset;
      sync_wr_gray = 4'b1100;
      m_ready = 1'b1;
      settle;
      chk("full_lvl8", 32'(rd_level), 32'd8);
      n = 0;
      while (!m_valid && n < 10) begin
         step;
         n++;
      end
      chk("full_first_lat", 32'(n), 32'd2);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("full_valid%0d", i), 32'(m_valid), 32'd1);
         chk($sformatf("full_data%0d", i),  32'(m_data),  32'(mem[i]));
         step;
      end
      chk("full_empty", 32'(empty),     32'd1);
      chk("full_vld0",  32'(m_valid),   32'd0);
      chk("full_gray",  32'(rd_gray),   32'(4'b1100));
      chk("full_addr",  32'(mem_raddr), 32'd0);

      // wrap past the pointer MSB toggle
      sync_wr_gray = gray(4'd13);
      settle;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("wrap_ren%0d", i),  32'(mem_ren),   32'd1);
         chk($sformatf("wrap_addr%0d", i), 32'(mem_raddr), 32'(i));
         step;
         chk($sformatf("wrap_gray%0d", i), 32'(rd_gray), 32'(gray(4'(9 + i))));
      end
      n = 0;
      while (!empty && n < 10) begin
         step;
         n++;
      end
      chk("wrap_empty",   32'(empty),    32'd1);
      chk("wrap_level",   32'(rd_level), 32'd0);
      chk("wrap_ptr_err", 32'(ptr_err),  32'd0);

      // illegal distance, then reset while data is buffered
      do_reset;
      sync_wr_gray = 4'b1101;
      settle;
      chk("err_lvl9", 32'(rd_level),  32'd9);
      chk("err_ren",  32'(mem_ren),   32'd1);
      chk("err_pre",  32'(ptr_err),   32'd0);
      step;
      chk("err_set",  32'(ptr_err),   32'd1);
      step;
      step;
      chk("err_sticky", 32'(ptr_err), 32'd1);
      chk("err_valid",  32'(m_valid), 32'd1);
      chk("err_data",   32'(m_data),  32'(mem[0]));
      rst_n = 1'b0;
      settle;
      chk("mid_rst_valid", 32'(m_valid), 32'd0);
      chk("mid_rst_data",  32'(m_data),  32'd0);
      chk("mid_rst_err",   32'(ptr_err), 32'd0);
      chk("mid_rst_gray",  32'(rd_gray), 32'd0);
      chk("mid_rst_ren",   32'(mem_ren), 32'd0);
      chk("mid_rst_addr",  32'(mem_raddr), 32'd0);
      sync_wr_gray = 4'd0;
      step;
      rst_n = 1'b1;
      settle;
      chk("post_rst_empty", 32'(empty), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
